int_img_stream: RTL

Streaming, parametrised integral-image engine for the Viola-Jones front end. It accepts one pixel per cycle in raster order and emits, for every pixel, the integral-image value and the squared integral-image value (sum of pixel² over the rectangle from (0,0) to the current (y,x)). It replaces the flat, fully combinational integral-image calculation, which cannot scale past small windows. A one-row line buffer of partial sums sits between the downscaler output and the window/feature evaluator.

---
 rtl/int_img_stream.sv | 137 +++++++++++++
 1 files changed

// File: rtl/int_img_stream.sv
// int_img_stream
//   Streaming integral-image engine. Accepts one unsigned pixel per cycle in
//   raster order and emits, per pixel, the integral value and (optionally) the
//   squared integral value over the rectangle (0,0)..(y,x). A single-row line
//   buffer holds the previous row's integrals; a row accumulator holds the
//   running sum of the current row.
//
// Parameters
//   WIDTH, HEIGHT : frame geometry (pixels per row, rows per frame)
//   PIX_W         : pixel width
//   ACC_W         : width of both integral outputs (wraps modulo 2^ACC_W)
//   EN_SQ         : 1 builds the squared path; 0 ties out_int_sq to 0
//
// Ports
//   clock, reset_n          : clock, synchronous active-low reset
//   in_pix/in_sof/in_valid  : input pixel, start-of-frame flag, valid
//   in_ready                : pixel can be accepted this cycle
//   out_int/out_int_sq      : integral and squared integral at (out_y,out_x)
//   out_x/out_y/out_last    : position of the output pixel, last-of-frame
//   out_valid/out_ready     : output handshake
module int_img_stream #(
  parameter int WIDTH  = 10,
  parameter int HEIGHT = 10,
  parameter int PIX_W  = 8,
  parameter int ACC_W  = 32,
  parameter int EN_SQ  = 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [PIX_W-1:0]          in_pix,
  input  logic                      in_sof,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [ACC_W-1:0]          out_int,
  output logic [ACC_W-1:0]          out_int_sq,
  output logic [$clog2(WIDTH)-1:0]  out_x,
  output logic [$clog2(HEIGHT)-1:0] out_y,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  logic [XW-1:0]    x, cur_x, nxt_x;
  logic [YW-1:0]    y, cur_y, nxt_y;
  logic             accept, row_start, first_row;
  logic [ACC_W-1:0] row_acc, r, above, sum;
  logic [ACC_W-1:0] lb [WIDTH];

  assign in_ready = !out_valid || out_ready;

  always_comb begin
    accept    = in_valid && in_ready;
    // An accepted start-of-frame overrides the counters for this pixel.
    cur_x     = in_sof ? '0 : x;
    cur_y     = in_sof ? '0 : y;
    row_start = (cur_x == '0);
    first_row = (cur_y == '0);
    nxt_x     = (cur_x == X_LAST) ? '0 : cur_x + 1'b1;
    nxt_y     = cur_y;
    if (cur_x == X_LAST) begin
      nxt_y = (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
    end
    r     = (row_start ? '0 : row_acc) + ACC_W'(in_pix);
    // Line-buffer contents are stale on the first row; masking replaces a clear.
    above = first_row ? '0 : lb[cur_x];
    sum   = r + above;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      x         <= '0;
      y         <= '0;
      row_acc   <= '0;
      out_valid <= 1'b0;
      out_int   <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      x         <= nxt_x;
      y         <= nxt_y;
      row_acc   <= r;
      out_valid <= 1'b1;
      out_int   <= sum;
      out_x     <= cur_x;
      out_y     <= cur_y;
      out_last  <= (cur_x == X_LAST) && (cur_y == Y_LAST);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Line buffer has no reset; only written on real accepts.
  always_ff @(posedge clock) begin
    if (reset_n && accept) begin
      lb[cur_x] <= sum;
    end
  end

  generate
    if (EN_SQ != 0) begin : g_sq
      logic [ACC_W-1:0] row_acc_sq, r_sq, sum_sq, pix_ext;
      logic [ACC_W-1:0] lb_sq [WIDTH];

      always_comb begin
        // Product of the zero-extended pixel, reduced modulo 2^ACC_W.
        pix_ext = ACC_W'(in_pix);
        r_sq    = (row_start ? '0 : row_acc_sq) + pix_ext * pix_ext;
        sum_sq  = r_sq + (first_row ? '0 : lb_sq[cur_x]);
      end

      always_ff @(posedge clock) begin
        if (!reset_n) begin
          row_acc_sq <= '0;
          out_int_sq <= '0;
        end else if (accept) begin
          row_acc_sq <= r_sq;
          out_int_sq <= sum_sq;
        end
      end

      always_ff @(posedge clock) begin
        if (reset_n && accept) begin
          lb_sq[cur_x] <= sum_sq;
        end
      end
    end else begin : g_nosq
      assign out_int_sq = '0;
    end
  endgenerate

endmodule
